demux_1x8_nbit_reg: RTL

Registered 1-to-8 N-bit distributor with a valid/ready handshake. It is the write-side counterpart of the 8:1 N-bit selector: one input word is steered into one of eight held output channels. The channel is chosen by an explicit select or by an internal round-robin pointer. Each channel has a one-cycle update strobe and a sticky "fresh" flag that blocks overwrite until the consumer acknowledges it. The block feeds per-channel consumers, such as display digits or edge-detector lanes, from a single producer.

---
 rtl/demux_pkg.sv | 11 +
 rtl/decoder_3x8_en.sv | 12 +
 rtl/demux_1x8_nbit_reg.sv | 87 ++++++++
 3 files changed

// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared constants and select decode helper for the 1x8 distributor
package demux_pkg;

  localparam int unsigned NUM_CH = 8;
  localparam int unsigned SEL_W  = 3;

  function automatic logic [NUM_CH-1:0] onehot8(input logic [SEL_W-1:0] sel);
    return NUM_CH'(1) << sel;
  endfunction

endpackage

// File: rtl/decoder_3x8_en.sv
// rtl/decoder_3x8_en.sv - 3-bit select plus enable to an 8-bit one-hot
module decoder_3x8_en
  import demux_pkg::*;
(
  input  logic [SEL_W-1:0]  sel_i,
  input  logic              en_i,
  output logic [NUM_CH-1:0] y_o
);

  assign y_o = en_i ? onehot8(sel_i) : '0;

endmodule

// File: rtl/demux_1x8_nbit_reg.sv
// rtl/demux_1x8_nbit_reg.sv - registered 1-to-8 N-bit distributor with per-channel fresh flags
module demux_1x8_nbit_reg
  import demux_pkg::*;
#(
  parameter int unsigned N = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [N-1:0]      d,
  input  logic [SEL_W-1:0]  s,
  input  logic              auto,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [NUM_CH-1:0] ack,
  output logic [N-1:0]      q0,
  output logic [N-1:0]      q1,
  output logic [N-1:0]      q2,
  output logic [N-1:0]      q3,
  output logic [N-1:0]      q4,
  output logic [N-1:0]      q5,
  output logic [N-1:0]      q6,
  output logic [N-1:0]      q7,
  output logic [NUM_CH-1:0] strobe,
  output logic [NUM_CH-1:0] fresh,
  output logic [SEL_W-1:0]  ptr
);

  logic [N-1:0]      q_q [NUM_CH];
  logic [NUM_CH-1:0] fresh_q, fresh_d;
  logic [NUM_CH-1:0] strobe_q;
  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic [SEL_W-1:0]  target;
  logic              accept;
  logic [NUM_CH-1:0] wr_en;

  assign target   = auto ? ptr_q : s;
  // A same-cycle ack frees the target channel, so the producer need not wait a cycle
  assign in_ready = ~fresh_q[target] | ack[target];
  assign accept   = in_valid & in_ready;

  decoder_3x8_en u_wr_dec (
    .sel_i (target),
    .en_i  (accept),
    .y_o   (wr_en)
  );

  always_comb begin
    fresh_d = (fresh_q & ~ack) | wr_en;
    ptr_d   = ptr_q;
    if (accept && auto) begin
      ptr_d = ptr_q + SEL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        q_q[i] <= '0;
      end
      fresh_q  <= '0;
      strobe_q <= '0;
      ptr_q    <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_en[i]) begin
          q_q[i] <= d;
        end
      end
      fresh_q  <= fresh_d;
      strobe_q <= wr_en;
      ptr_q    <= ptr_d;
    end
  end

  assign q0     = q_q[0];
  assign q1     = q_q[1];
  assign q2     = q_q[2];
  assign q3     = q_q[3];
  assign q4     = q_q[4];
  assign q5     = q_q[5];
  assign q6     = q_q[6];
  assign q7     = q_q[7];
  assign strobe = strobe_q;
  assign fresh  = fresh_q;
  assign ptr    = ptr_q;

endmodule
